bidir_port_ctrl: RTL and testbench
==================================

BIDIR_PORT_CTRL -- requirements
Module: bidir_port_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, bit width of the bidirectional port.
REQ-002 Parameter SYNC_STAGES, default 2, input synchroniser depth; legal range 1..4.
REQ-003 Parameter TURN_CYCLES, default 2, bus turnaround dead cycles; legal range 1..15.
REQ-004 Clocking: one clock, clk; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 dir_req  in  1  requested direction: 1 = drive port (TO_PORT), 0 = receive (FROM_PORT); level-sensitive.
REQ-008 wr_valid  in  1  write data offered.
REQ-009 wr_data  in  WIDTH  data to drive onto port.
REQ-010 wr_ready  out  1  write accepted when wr_valid & wr_ready.
REQ-011 rd_valid  out  1  rd_data is a valid synchronised port sample.
REQ-012 rd_data  out  WIDTH  synchronised port sample.
REQ-013 rd_changed  out  1  one-cycle pulse: rd_data differs from its previous valid value.
REQ-014 port_in  in  WIDTH  raw pad input, asynchronous to clk.
REQ-015 port_out  out  WIDTH  pad output data, to top-level tri-state buffer.
REQ-016 port_oe  out  1  pad tri-state enable; 0 = high-Z.
REQ-017 port_dir  out  1  external level-shifter direction, 1 = toward pad.
REQ-018 busy  out  1  high in any turnaround/flush state.

Function
REQ-019 FSM states SHALL be IN, TURN_OUT, OUT, TURN_IN, FLUSH; all outputs registered.
REQ-020 IN: port_dir=0, port_oe=0, wr_ready=0, rd_valid=1; dir_req=1 -> TURN_OUT, port_dir=1 from next cycle.
REQ-021 TURN_OUT: port_dir=1, port_oe=0 for exactly TURN_CYCLES cycles, then OUT.
REQ-022 OUT: port_dir=1, port_oe=1, wr_ready=1, rd_valid=0; dir_req=0 -> TURN_IN, port_oe=0 from next cycle.
REQ-023 TURN_IN: port_oe=0, port_dir=1 for exactly TURN_CYCLES cycles, then FLUSH with port_dir=0.
REQ-024 FLUSH: port_dir=0, port_oe=0, rd_valid=0 for SYNC_STAGES cycles, then IN.
REQ-025 port_oe and port_dir SHALL never be 1/0 respectively in the same cycle (driving into a receive buffer forbidden).
REQ-026 Write accepted on edge where wr_valid & wr_ready; port_out updates on that edge, holds otherwise; wr_data outside OUT ignored.
REQ-027 port_out SHALL retain its last value through TURN_IN, FLUSH, IN.
REQ-028 port_in passes SYNC_STAGES flop chain; rd_data = chain output, updated every cycle in all states.
REQ-029 rd_changed=1 in IN when rd_data differs from value one cycle earlier and rd_valid was 1 the previous cycle; never in first IN cycle after FLUSH.
REQ-030 dir_req toggled during TURN_OUT/TURN_IN/FLUSH SHALL be ignored until the sequence completes; re-evaluated in steady state, so TURN_IN->FLUSH->IN->TURN_OUT on dir_req=1 at sequence end.
REQ-031 Turnaround counter width $clog2(TURN_CYCLES+1); no wrap; reloaded on each state entry.
REQ-032 busy=1 in TURN_OUT, TURN_IN, FLUSH; 0 in IN, OUT.

Reset
REQ-033 On reset: state FLUSH, port_dir=0, port_oe=0, port_out=0, wr_ready=0, rd_valid=0, rd_changed=0, busy=1, synchroniser cleared to 0.
REQ-034 Reset asserted mid-turnaround or in OUT SHALL deassert port_oe on the next edge regardless of dir_req.
REQ-035 After reset release, FLUSH runs SYNC_STAGES cycles then IN, even if dir_req=1.

Verification
REQ-036 Defaults, reset release with dir_req=0 -> rd_valid=1 at cycle 2, busy=0, port_oe=0.
REQ-037 dir_req 0->1 sampled edge N -> port_dir=1 after N, port_oe=1 and wr_ready=1 after N+2; write 0xA5 -> port_out=0xA5 next edge.
REQ-038 dir_req 1->0 edge M -> port_oe=0 after M, port_dir=0 after M+2, rd_valid=1 after M+4; port_out stays 0xA5.
REQ-039 In IN, port_in 0x00->0x3C -> rd_data=0x3C after 2 edges, rd_changed single-cycle pulse.
REQ-040 dir_req pulsed 1 for one cycle in IN -> full TURN_OUT completes, OUT one cycle, then TURN_IN; assertion port_oe->port_dir checked every cycle.
REQ-041 Reset asserted in OUT with wr_valid=1 -> port_oe=0, port_out=0 next edge, no write accepted.

Source files
------------

// File: rtl/bidir_port_ctrl.sv
// Bidirectional pad controller: sequences the level-shifter direction and the
// tri-state enable around bus turnaround, and synchronises the pad input.
module bidir_port_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dir_req,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_changed,
  input  logic [WIDTH-1:0] port_in,
  output logic [WIDTH-1:0] port_out,
  output logic             port_oe,
  output logic             port_dir,
  output logic             busy
);

  localparam logic [2:0] S_IN       = 3'd0;
  localparam logic [2:0] S_TURN_OUT = 3'd1;
  localparam logic [2:0] S_OUT      = 3'd2;
  localparam logic [2:0] S_TURN_IN  = 3'd3;
  localparam logic [2:0] S_FLUSH    = 3'd4;

  localparam int TC_W = $clog2(TURN_CYCLES + 1);
  localparam int FC_W = $clog2(SYNC_STAGES + 1);
  localparam logic [TC_W-1:0] TC_LOAD = TC_W'(TURN_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(SYNC_STAGES - 1);

  logic [2:0]      state_q, state_d;
  logic [TC_W-1:0] tcnt_q, tcnt_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] port_out_q, port_out_d;
  logic port_oe_q, port_oe_d, port_dir_q, port_dir_d;
  logic wr_ready_q, wr_ready_d, rd_valid_q, rd_valid_d;
  logic rd_changed_q, rd_changed_d, busy_q, busy_d;

  always_comb begin
    sync_d[0] = port_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // dir_req is only looked at in the steady states; the sequences run to completion.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IN: if (dir_req) begin
        state_d = S_TURN_OUT;
        tcnt_d  = TC_LOAD;
      end
      S_TURN_OUT: if (tcnt_q == '0) state_d = S_OUT;
                  else tcnt_d = tcnt_q - TC_W'(1);
      S_OUT: if (!dir_req) begin
        state_d = S_TURN_IN;
        tcnt_d  = TC_LOAD;
      end
      S_TURN_IN: if (tcnt_q == '0) begin
        state_d = S_FLUSH;
        fcnt_d  = FC_LOAD;
      end else tcnt_d = tcnt_q - TC_W'(1);
      S_FLUSH: if (fcnt_q == '0) state_d = S_IN;
               else fcnt_d = fcnt_q - FC_W'(1);
      default: begin
        state_d = S_FLUSH;
        fcnt_d  = FC_LOAD;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as state_q.
  always_comb begin
    port_dir_d   = (state_d == S_TURN_OUT) || (state_d == S_OUT) || (state_d == S_TURN_IN);
    port_oe_d    = (state_d == S_OUT);
    wr_ready_d   = (state_d == S_OUT);
    rd_valid_d   = (state_d == S_IN);
    busy_d       = (state_d == S_TURN_OUT) || (state_d == S_TURN_IN) || (state_d == S_FLUSH);
    port_out_d   = (wr_valid && wr_ready_q) ? wr_data : port_out_q;
    rd_changed_d = (state_d == S_IN) && rd_valid_q &&
                   (sync_d[SYNC_STAGES-1] != sync_q[SYNC_STAGES-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FLUSH;
      tcnt_q       <= TC_LOAD;
      fcnt_q       <= FC_LOAD;
      sync_q       <= '0;
      port_out_q   <= '0;
      port_oe_q    <= 1'b0;
      port_dir_q   <= 1'b0;
      wr_ready_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_changed_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      fcnt_q       <= fcnt_d;
      sync_q       <= sync_d;
      port_out_q   <= port_out_d;
      port_oe_q    <= port_oe_d;
      port_dir_q   <= port_dir_d;
      wr_ready_q   <= wr_ready_d;
      rd_valid_q   <= rd_valid_d;
      rd_changed_q <= rd_changed_d;
      busy_q       <= busy_d;
    end
  end

  assign rd_data    = sync_q[SYNC_STAGES-1];
  assign port_out   = port_out_q;
  assign port_oe    = port_oe_q;
  assign port_dir   = port_dir_q;
  assign wr_ready   = wr_ready_q;
  assign rd_valid   = rd_valid_q;
  assign rd_changed = rd_changed_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Directed bench for bidir_port_ctrl at default parameters (WIDTH=8, 2 sync stages, 2 turn cycles).
module tb_bidir_port_ctrl;

  logic       clk = 1'b0;
  logic       reset, dir_req, wr_valid;
  logic [7:0] wr_data, port_in;
  logic       wr_ready, rd_valid, rd_changed, port_oe, port_dir, busy;
  logic [7:0] rd_data, port_out;

  int n_vec = 0;
  int n_bad = 0;
  bit done  = 1'b0;

  bidir_port_ctrl dut (
    .clk(clk), .reset(reset), .dir_req(dir_req), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_changed(rd_changed), .port_in(port_in),
    .port_out(port_out), .port_oe(port_oe), .port_dir(port_dir), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driving into a receive-direction level shifter must never happen.
  always @(negedge clk) if (!done && reset === 1'b0) chk("oe_without_dir", port_oe & ~port_dir, 0);

  initial begin
    reset = 1'b1; dir_req = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; port_in = 8'h00;
    tick(); tick();
    chk("rst_dir", port_dir, 0);   chk("rst_oe", port_oe, 0);
    chk("rst_out", port_out, 0);   chk("rst_ready", wr_ready, 0);
    chk("rst_rdv", rd_valid, 0);   chk("rst_chg", rd_changed, 0);
    chk("rst_busy", busy, 1);      chk("rst_rdata", rd_data, 0);

    // Reset release: FLUSH for two cycles then IN
    reset = 1'b0;
    tick(); chk("rel1_rdv", rd_valid, 0); chk("rel1_busy", busy, 1);
    tick(); chk("rel2_rdv", rd_valid, 1); chk("rel2_busy", busy, 0); chk("rel2_oe", port_oe, 0);

    // Input change propagates through two stages, one-cycle change pulse
    port_in = 8'h3C;
    tick(); chk("sync1_rdata", rd_data, 8'h00); chk("sync1_chg", rd_changed, 0);
    tick(); chk("sync2_rdata", rd_data, 8'h3C); chk("sync2_chg", rd_changed, 1);
    tick(); chk("sync3_rdata", rd_data, 8'h3C); chk("sync3_chg", rd_changed, 0);

    // IN -> TURN_OUT -> OUT, write 0xA5
    dir_req = 1'b1;
    tick(); chk("to_n_dir", port_dir, 1); chk("to_n_oe", port_oe, 0);
            chk("to_n_busy", busy, 1);    chk("to_n_rdv", rd_valid, 0); chk("to_n_rdy", wr_ready, 0);
    tick(); chk("to_n1_oe", port_oe, 0);  chk("to_n1_dir", port_dir, 1);
    tick(); chk("to_n2_oe", port_oe, 1);  chk("to_n2_rdy", wr_ready, 1); chk("to_n2_busy", busy, 0);
    wr_valid = 1'b1; wr_data = 8'hA5;
    tick(); chk("wr_out", port_out, 8'hA5);
    wr_valid = 1'b0; wr_data = 8'hFF;
    tick(); chk("wr_hold", port_out, 8'hA5);

    // OUT -> TURN_IN -> FLUSH -> IN; writes during turnaround are ignored
    dir_req = 1'b0;
    tick(); chk("ti_m_oe", port_oe, 0); chk("ti_m_dir", port_dir, 1);
            chk("ti_m_busy", busy, 1);  chk("ti_m_rdy", wr_ready, 0);
    wr_valid = 1'b1; wr_data = 8'h11;
    tick(); chk("ti_m1_dir", port_dir, 1); chk("ti_m1_out", port_out, 8'hA5);
    tick(); chk("ti_m2_dir", port_dir, 0); chk("ti_m2_rdv", rd_valid, 0); chk("ti_m2_busy", busy, 1);
    wr_valid = 1'b0;
    port_in = 8'h5A;
    tick(); chk("ti_m3_rdv", rd_valid, 0);
    tick(); chk("ti_m4_rdv", rd_valid, 1); chk("ti_m4_out", port_out, 8'hA5);
            chk("ti_m4_rdata", rd_data, 8'h5A); chk("ti_m4_chg", rd_changed, 0);

    // One-cycle dir_req pulse: full round trip, dir_req raised in FLUSH is deferred
    dir_req = 1'b1;
    tick(); chk("p0_dir", port_dir, 1);
    dir_req = 1'b0;
    tick(); chk("p1_dir", port_dir, 1); chk("p1_oe", port_oe, 0); chk("p1_busy", busy, 1);
    tick(); chk("p2_oe", port_oe, 1);
    tick(); chk("p3_oe", port_oe, 0); chk("p3_dir", port_dir, 1);
    tick(); chk("p4_dir", port_dir, 1);
    tick(); chk("p5_dir", port_dir, 0); chk("p5_busy", busy, 1);
    dir_req = 1'b1;
    tick(); chk("p6_rdv", rd_valid, 0); chk("p6_dir", port_dir, 0);
    tick(); chk("p7_rdv", rd_valid, 1); chk("p7_dir", port_dir, 0);
    tick(); chk("p8_dir", port_dir, 1); chk("p8_rdv", rd_valid, 0);
    tick();
    tick(); chk("p10_oe", port_oe, 1);

    // Reset in OUT with a write offered: enable drops, port_out clears, no write
    reset = 1'b1; wr_valid = 1'b1; wr_data = 8'h77;
    tick(); chk("ro_oe", port_oe, 0); chk("ro_out", port_out, 0); chk("ro_dir", port_dir, 0);
            chk("ro_rdy", wr_ready, 0); chk("ro_busy", busy, 1); chk("ro_rdata", rd_data, 0);
    wr_valid = 1'b0;
    reset = 1'b0;   // dir_req still 1: FLUSH must still finish into IN
    tick(); chk("rr1_rdv", rd_valid, 0); chk("rr1_dir", port_dir, 0);
    tick(); chk("rr2_rdv", rd_valid, 1); chk("rr2_dir", port_dir, 0);
    tick(); chk("rr3_dir", port_dir, 1); chk("rr3_oe", port_oe, 0);

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
